// File: rtl/enc_pkg.sv
// Shared constants and a reference priority function for the 8-to-3 encoder.
package enc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CODE_W_DEF = 3;

  // Index of the highest set bit; zero when no bit is set.
  function automatic logic [CODE_W_DEF-1:0] prio_idx(input logic [DATA_W_DEF-1:0] vec);
    logic [CODE_W_DEF-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(DATA_W_DEF); i++) begin
      if (vec[i]) idx = CODE_W_DEF'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc_prio_core.sv
// Combinational MSB-first priority scan; multi-hot flag built only with ENC_MULTIHOT_DET_EN.
module enc_prio_core
  import enc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned CODE_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] idx,
  output logic              any
`ifdef ENC_MULTIHOT_DET_EN
  ,
  output logic              multi
`endif
);

  // LSB-to-MSB scan: the last hit overwrites, so the highest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
`ifdef ENC_MULTIHOT_DET_EN
    multi = 1'b0;
`endif
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (data[i]) begin
`ifdef ENC_MULTIHOT_DET_EN
        // A second hit after an earlier one means popcount > 1.
        if (any) multi = 1'b1;
`endif
        idx = CODE_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder with valid flag.
// Optional multi-hot detect output enabled by macro ENC_MULTIHOT_DET_EN.
module encoder_8x3
  import enc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned CODE_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code,
  output logic              valid
`ifdef ENC_MULTIHOT_DET_EN
  ,
  output logic              multi
`endif
);

  logic [CODE_W-1:0] idx;
  logic              any;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;

`ifdef ENC_MULTIHOT_DET_EN
  logic multi_c;
  logic multi_q;

  enc_prio_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .data  (data),
    .idx   (idx),
    .any   (any),
    .multi (multi_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multi_q <= 1'b0;
    end else if (en) begin
      multi_q <= multi_c;
    end
  end

  assign multi = multi_q;
`else
  enc_prio_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .data (data),
    .idx  (idx),
    .any  (any)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      code_q  <= idx;
      valid_q <= any;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_encoder_8x3.sv
// Directed self-checking bench for encoder_8x3; multi checks compiled in with ENC_MULTIHOT_DET_EN.
module tb_encoder_8x3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic [2:0] code;
  logic       valid;
`ifdef ENC_MULTIHOT_DET_EN
  logic       multi;
`endif

  int errors = 0;
  int checks = 0;

  encoder_8x3 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .data  (data),
    .code  (code),
    .valid (valid)
`ifdef ENC_MULTIHOT_DET_EN
    ,
    .multi (multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    data = 8'hFF;
    #3;
    checks++;
    if (code !== 3'd0) begin
      errors++; $display("FAIL reset_code: got %0d want 0", code);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", valid);
    end
`ifdef ENC_MULTIHOT_DET_EN
    checks++;
    if (multi !== 1'b0) begin
      errors++; $display("FAIL reset_multi: got %b want 0", multi);
    end
`endif
    step();
    checks++;
    if (code !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL reset_held_edge: got code=%0d valid=%b want 0/0", code, valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (code !== 3'd7 || valid !== 1'b1) begin
      errors++; $display("FAIL reset_release: got code=%0d valid=%b want 7/1", code, valid);
    end
`ifdef ENC_MULTIHOT_DET_EN
    checks++;
    if (multi !== 1'b1) begin
      errors++; $display("FAIL reset_release_multi: got %b want 1", multi);
    end
`endif
  endtask

  task automatic test_sweep();
    en   = 1'b1;
    data = 8'h00;
    step();
    checks++;
    if (code !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL sweep_zero: got code=%0d valid=%b want 0/0", code, valid);
    end
    for (int i = 0; i < 8; i++) begin
      data = 8'h01 << i;
      step();
      checks++;
      if (code !== 3'(i) || valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep_onehot[%0d]: got code=%0d valid=%b want %0d/1", i, code, valid, i);
      end
`ifdef ENC_MULTIHOT_DET_EN
      checks++;
      if (multi !== 1'b0) begin
        errors++; $display("FAIL sweep_multi[%0d]: got %b want 0", i, multi);
      end
`endif
    end
  endtask

  task automatic test_priority();
    en   = 1'b1;
    data = 8'b0010_0110;
    step();
    checks++;
    if (code !== 3'd5 || valid !== 1'b1) begin
      errors++; $display("FAIL prio_26: got code=%0d valid=%b want 5/1", code, valid);
    end
`ifdef ENC_MULTIHOT_DET_EN
    checks++;
    if (multi !== 1'b1) begin
      errors++; $display("FAIL prio_26_multi: got %b want 1", multi);
    end
`endif
    data = 8'b1000_0001;
    step();
    checks++;
    if (code !== 3'd7 || valid !== 1'b1) begin
      errors++; $display("FAIL prio_81: got code=%0d valid=%b want 7/1", code, valid);
    end
`ifdef ENC_MULTIHOT_DET_EN
    checks++;
    if (multi !== 1'b1) begin
      errors++; $display("FAIL prio_81_multi: got %b want 1", multi);
    end
`endif
  endtask

  task automatic test_hold();
    en   = 1'b1;
    data = 8'h08;
    step();
    checks++;
    if (code !== 3'd3 || valid !== 1'b1) begin
      errors++; $display("FAIL hold_load: got code=%0d valid=%b want 3/1", code, valid);
    end
    en   = 1'b0;
    data = 8'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (code !== 3'd3 || valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got code=%0d valid=%b want 3/1", i, code, valid);
      end
    end
    data = 8'h00;
    step();
    checks++;
    if (code !== 3'd3 || valid !== 1'b1) begin
      errors++; $display("FAIL hold_zero_data: got code=%0d valid=%b want 3/1", code, valid);
    end
`ifdef ENC_MULTIHOT_DET_EN
    checks++;
    if (multi !== 1'b0) begin
      errors++; $display("FAIL hold_multi: got %b want 0", multi);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [4];
    logic [2:0] exp_code [4];
    logic       exp_valid [4];
    vec[0] = 8'hFF; exp_code[0] = 3'd7; exp_valid[0] = 1'b1;
    vec[1] = 8'h00; exp_code[1] = 3'd0; exp_valid[1] = 1'b0;
    vec[2] = 8'h3C; exp_code[2] = 3'd5; exp_valid[2] = 1'b1;
    vec[3] = 8'h10; exp_code[3] = 3'd4; exp_valid[3] = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = vec[i];
      step();
      checks++;
      if (code !== exp_code[i] || valid !== exp_valid[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got code=%0d valid=%b want %0d/%b", i, code, valid,
                 exp_code[i], exp_valid[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    en   = 1'b1;
    data = 8'h40;
    step();
    checks++;
    if (code !== 3'd6 || valid !== 1'b1) begin
      errors++; $display("FAIL async_preload: got code=%0d valid=%b want 6/1", code, valid);
    end
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (code !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL async_clear: got code=%0d valid=%b want 0/0", code, valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (code !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL async_after_en0: got code=%0d valid=%b want 0/0", code, valid);
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    data = 8'h00;
    test_reset();
    test_sweep();
    test_priority();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
